// File: rtl/ps2_ascii_decoder.sv
// Set-2 scan bytes to ASCII with Shift/Caps tracking; one character per key press lands in the FIFO
// the cycle after its final byte. A full FIFO with no same-cycle pop drops the character and sets overflow.
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH      = 8,
  parameter bit SUPPRESS_REPEAT = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            shift_held,
  output logic                            caps_on,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  // {hit, is_letter, unshifted char, shifted char}
  function automatic logic [17:0] map_code(input logic [7:0] code);
    logic [17:0] r;
    r = '0;
    case (code)
      8'h45: r = {2'b10, 8'h30, 8'h29};  8'h16: r = {2'b10, 8'h31, 8'h21};
      8'h1E: r = {2'b10, 8'h32, 8'h40};  8'h26: r = {2'b10, 8'h33, 8'h23};
      8'h25: r = {2'b10, 8'h34, 8'h24};  8'h2E: r = {2'b10, 8'h35, 8'h25};
      8'h36: r = {2'b10, 8'h36, 8'h5E};  8'h3D: r = {2'b10, 8'h37, 8'h26};
      8'h3E: r = {2'b10, 8'h38, 8'h2A};  8'h46: r = {2'b10, 8'h39, 8'h28};
      8'h52: r = {2'b10, 8'h27, 8'h22};  8'h41: r = {2'b10, 8'h2C, 8'h3C};
      8'h4E: r = {2'b10, 8'h2D, 8'h5F};  8'h49: r = {2'b10, 8'h2E, 8'h3E};
      8'h4A: r = {2'b10, 8'h2F, 8'h3F};  8'h4C: r = {2'b10, 8'h3B, 8'h3A};
      8'h55: r = {2'b10, 8'h3D, 8'h2B};  8'h54: r = {2'b10, 8'h5B, 8'h7B};
      8'h5D: r = {2'b10, 8'h5C, 8'h7C};  8'h5B: r = {2'b10, 8'h5D, 8'h7D};
      8'h0E: r = {2'b10, 8'h60, 8'h7E};
      8'h1C: r = {2'b11, 8'h61, 8'h41};  8'h32: r = {2'b11, 8'h62, 8'h42};
      8'h21: r = {2'b11, 8'h63, 8'h43};  8'h23: r = {2'b11, 8'h64, 8'h44};
      8'h24: r = {2'b11, 8'h65, 8'h45};  8'h2B: r = {2'b11, 8'h66, 8'h46};
      8'h34: r = {2'b11, 8'h67, 8'h47};  8'h33: r = {2'b11, 8'h68, 8'h48};
      8'h43: r = {2'b11, 8'h69, 8'h49};  8'h3B: r = {2'b11, 8'h6A, 8'h4A};
      8'h42: r = {2'b11, 8'h6B, 8'h4B};  8'h4B: r = {2'b11, 8'h6C, 8'h4C};
      8'h3A: r = {2'b11, 8'h6D, 8'h4D};  8'h31: r = {2'b11, 8'h6E, 8'h4E};
      8'h44: r = {2'b11, 8'h6F, 8'h4F};  8'h4D: r = {2'b11, 8'h70, 8'h50};
      8'h15: r = {2'b11, 8'h71, 8'h51};  8'h2D: r = {2'b11, 8'h72, 8'h52};
      8'h1B: r = {2'b11, 8'h73, 8'h53};  8'h2C: r = {2'b11, 8'h74, 8'h54};
      8'h3C: r = {2'b11, 8'h75, 8'h55};  8'h2A: r = {2'b11, 8'h76, 8'h56};
      8'h1D: r = {2'b11, 8'h77, 8'h57};  8'h22: r = {2'b11, 8'h78, 8'h58};
      8'h35: r = {2'b11, 8'h79, 8'h59};  8'h1A: r = {2'b11, 8'h7A, 8'h5A};
      8'h29: r = {2'b10, 8'h20, 8'h20};  8'h5A: r = {2'b10, 8'h0D, 8'h0D};
      8'h66: r = {2'b10, 8'h08, 8'h08};  8'h0D: r = {2'b10, 8'h09, 8'h09};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            lshift_q, lshift_d, rshift_q, rshift_d;
  logic            caps_q, caps_d, caps_held_q, caps_held_d;
  logic            rpt_vld_q, rpt_vld_d;
  logic [7:0]      rpt_code_q, rpt_code_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            is_make, is_break;
  logic            map_hit, map_letter, use_upper, is_repeat, push, pop, full, wr_en;
  logic [7:0]      map_lo, map_up, char_dat;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        S_IDLE:  state_d = (scan_code == 8'hF0) ? S_BRK :
                           (scan_code == 8'hE0) ? S_EXT : S_IDLE;
        S_EXT:   state_d = (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    case (state_q)
      S_IDLE:  is_make  = scan_valid && (scan_code != 8'hF0) && (scan_code != 8'hE0);
      S_BRK:   is_break = scan_valid;
      default: ;
    endcase
  end

  // Character is mapped with the modifier state registered before this byte.
  assign {map_hit, map_letter, map_lo, map_up} = map_code(scan_code);
  assign shift_held = lshift_q | rshift_q;
  assign use_upper  = map_letter ? (shift_held ^ caps_q) : shift_held;
  assign char_dat   = use_upper ? map_up : map_lo;
  assign is_repeat  = SUPPRESS_REPEAT && rpt_vld_q && (rpt_code_q == scan_code);
  assign push       = is_make && map_hit && !is_repeat;

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    rpt_vld_d   = rpt_vld_q;
    rpt_code_d  = rpt_code_q;
    if (is_make) begin
      if (scan_code == 8'h12) lshift_d = 1'b1;
      if (scan_code == 8'h59) rshift_d = 1'b1;
      if (scan_code == 8'h58) begin
        if (!caps_held_q) caps_d = ~caps_q;
        caps_held_d = 1'b1;
      end
    end
    if (is_break) begin
      if (scan_code == 8'h12) lshift_d = 1'b0;
      if (scan_code == 8'h59) rshift_d = 1'b0;
      if (scan_code == 8'h58) caps_held_d = 1'b0;
    end
    if (SUPPRESS_REPEAT) begin
      if (is_make && map_hit) begin
        rpt_vld_d  = 1'b1;
        rpt_code_d = scan_code;
      end else if (is_break && rpt_vld_q && (rpt_code_q == scan_code)) begin
        rpt_vld_d = 1'b0;
      end
    end
  end

  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign pop   = out_valid && out_ready;
  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (push && full && !pop);
    level_d  = level_q + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, pop};
    if (wr_en) begin
      mem_d[wr_ptr_q] = char_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      rpt_vld_q   <= 1'b0;
      rpt_code_q  <= 8'h00;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      rpt_vld_q   <= rpt_vld_d;
      rpt_code_q  <= rpt_code_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign caps_on    = caps_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench: table of scan bytes with expected outputs, plus FIFO, repeat and reset sequences.
module tb_ps2_ascii_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       out_ready;

  logic [7:0] d0_data, d1_data;
  logic       d0_vld, d1_vld, d0_shift, d1_shift, d0_caps, d1_caps, d0_ovf, d1_ovf;
  logic [3:0] d0_lvl, d1_lvl;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
    .out_data(d0_data), .out_valid(d0_vld), .out_ready(out_ready),
    .shift_held(d0_shift), .caps_on(d0_caps), .overflow(d0_ovf), .fifo_level(d0_lvl)
  );

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
    .out_data(d1_data), .out_valid(d1_vld), .out_ready(out_ready),
    .shift_held(d1_shift), .caps_on(d1_caps), .overflow(d1_ovf), .fifo_level(d1_lvl)
  );

  typedef struct {
    logic [7:0] code;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_shift;
    logic       exp_caps;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic v, input logic [7:0] d,
                     input logic s, input logic k);
    vec_t t;
    t.code = c; t.exp_vld = v; t.exp_dat = d; t.exp_shift = s; t.exp_caps = k;
    tbl.push_back(t);
  endtask

  task automatic send(input logic [7:0] c);
    scan_code  = c;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  // Pops dut0 until empty (bounded), comparing against exp_q in order.
  task automatic drain0();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (!d0_vld) break;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_extra: got 0x%0h expected no entry", d0_data);
      end else begin
        chk("drain_dat", d0_data, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_vld_low", d0_vld, 0);
    chk("drain_lvl", d0_lvl, 0);
  endtask

  initial begin
    rst = 1'b1; scan_code = 8'h00; scan_valid = 1'b0; out_ready = 1'b0;

    //   code   vld dat    sh ck
    add(8'h1C, 1, 8'h61, 0, 0); add(8'hF0, 0, 8'h00, 0, 0); add(8'h1C, 0, 8'h00, 0, 0);
    add(8'h12, 0, 8'h00, 1, 0); add(8'h1C, 1, 8'h41, 1, 0); add(8'h16, 1, 8'h21, 1, 0);
    add(8'hF0, 0, 8'h00, 1, 0); add(8'h12, 0, 8'h00, 0, 0); add(8'h1C, 1, 8'h61, 0, 0);
    add(8'h58, 0, 8'h00, 0, 1); add(8'hF0, 0, 8'h00, 0, 1); add(8'h58, 0, 8'h00, 0, 1);
    add(8'h1C, 1, 8'h41, 0, 1); add(8'h12, 0, 8'h00, 1, 1); add(8'h1C, 1, 8'h61, 1, 1);
    add(8'h16, 1, 8'h21, 1, 1); add(8'hF0, 0, 8'h00, 1, 1); add(8'h12, 0, 8'h00, 0, 1);
    add(8'h58, 0, 8'h00, 0, 0); add(8'h58, 0, 8'h00, 0, 0); add(8'h58, 0, 8'h00, 0, 0);
    add(8'h1C, 1, 8'h61, 0, 0); add(8'hF0, 0, 8'h00, 0, 0); add(8'h58, 0, 8'h00, 0, 0);
    add(8'h58, 0, 8'h00, 0, 1); add(8'h45, 1, 8'h30, 0, 1); add(8'h1A, 1, 8'h5A, 0, 1);
    add(8'hF0, 0, 8'h00, 0, 1); add(8'h58, 0, 8'h00, 0, 1); add(8'h58, 0, 8'h00, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0); add(8'h58, 0, 8'h00, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0); add(8'h75, 0, 8'h00, 0, 0); add(8'hE0, 0, 8'h00, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0); add(8'h75, 0, 8'h00, 0, 0); add(8'hE0, 0, 8'h00, 0, 0);
    add(8'h12, 0, 8'h00, 0, 0); add(8'h1C, 1, 8'h61, 0, 0);
    add(8'h59, 0, 8'h00, 1, 0); add(8'h0E, 1, 8'h7E, 1, 0); add(8'h5D, 1, 8'h7C, 1, 0);
    add(8'h4C, 1, 8'h3A, 1, 0); add(8'hF0, 0, 8'h00, 1, 0); add(8'h59, 0, 8'h00, 0, 0);
    add(8'h29, 1, 8'h20, 0, 0); add(8'h5A, 1, 8'h0D, 0, 0); add(8'h4E, 1, 8'h2D, 0, 0);
    add(8'h66, 1, 8'h08, 0, 0); add(8'h76, 0, 8'h00, 0, 0); add(8'h0D, 1, 8'h09, 0, 0);
    add(8'h15, 1, 8'h71, 0, 0);

    @(posedge clk); @(posedge clk); #1;
    chk("rst_vld", d0_vld, 0);   chk("rst_dat", d0_data, 8'h00);
    chk("rst_lvl", d0_lvl, 0);   chk("rst_shift", d0_shift, 0);
    chk("rst_caps", d0_caps, 0); chk("rst_ovf", d0_ovf, 0);
    chk("rst1_vld", d1_vld, 0);  chk("rst1_lvl", d1_lvl, 0);
    rst = 1'b0;

    out_ready = 1'b1;
    foreach (tbl[i]) begin
      scan_code  = tbl[i].code;
      scan_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_vld", i), d0_vld, tbl[i].exp_vld);
      if (tbl[i].exp_vld) chk($sformatf("vec%0d_dat", i), d0_data, tbl[i].exp_dat);
      chk($sformatf("vec%0d_shift", i), d0_shift, tbl[i].exp_shift);
      chk($sformatf("vec%0d_caps", i), d0_caps, tbl[i].exp_caps);
    end
    scan_valid = 1'b0;
    @(posedge clk); #1;
    chk("tbl_end_lvl", d0_lvl, 0);
    out_ready = 1'b0;

    // Fill past capacity with out_ready low.
    for (int p = 0; p < 9; p++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
      if (p == 7) begin
        chk("fill8_lvl", d0_lvl, 8);
        chk("fill8_ovf", d0_ovf, 0);
      end
    end
    chk("fill9_lvl", d0_lvl, 8);
    chk("fill9_ovf", d0_ovf, 1);
    chk("fill9_vld", d0_vld, 1);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61);
    drain0();
    chk("ovf_sticky", d0_ovf, 1);

    // Full FIFO with simultaneous pop and push keeps the level.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h1C);
    chk("refill_lvl", d0_lvl, 8);
    out_ready = 1'b1;
    send(8'h16);
    chk("pushpop_lvl", d0_lvl, 8);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h61);
    exp_q.push_back(8'h31);
    drain0();

    // Repeat suppression on dut1; dut0 keeps every repeat.
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("rpt1_lvl", d1_lvl, 2);
    chk("rpt1_dat", d1_data, 8'h61);
    chk("rpt0_lvl", d0_lvl, 4);

    // Reset in the middle of a break prefix, with a same-cycle byte.
    send(8'h12); send(8'h58); send(8'hF0);
    chk("pre_rst_shift", d1_shift, 1);
    chk("pre_rst_caps", d1_caps, 1);
    rst = 1'b1; scan_code = 8'h1C; scan_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; scan_valid = 1'b0;
    chk("mrst1_lvl", d1_lvl, 0);    chk("mrst1_vld", d1_vld, 0);
    chk("mrst1_dat", d1_data, 0);   chk("mrst1_shift", d1_shift, 0);
    chk("mrst1_caps", d1_caps, 0);  chk("mrst1_ovf", d1_ovf, 0);
    chk("mrst0_lvl", d0_lvl, 0);    chk("mrst0_shift", d0_shift, 0);
    chk("mrst0_caps", d0_caps, 0);  chk("mrst0_ovf", d0_ovf, 0);
    send(8'h1C);
    chk("post_rst1_vld", d1_vld, 1);
    chk("post_rst1_dat", d1_data, 8'h61);
    chk("post_rst0_dat", d0_data, 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
